// File: rtl/xm_mem_pkg.sv
// -----------------------------------------------------------------------------
// xm_mem_pkg
// Shared types and constants for the X-Makina data-side memory sequencer.
//   WORD / BYTE    : data word width and byte-lane width in bits
//   BYTES / ADDR_W : memory size in bytes and byte-address width
//   WR_SIZE_*      : encodings of the memory write-size port
//   mem_state_t    : sequencer states (FAULT is only reachable when
//                    MEM_ACCESS_ALIGN_CHECK_EN is defined)
// -----------------------------------------------------------------------------
package xm_mem_pkg;

  localparam int WORD   = 16;
  localparam int BYTE   = 8;
  localparam int BYTES  = 65536;
  localparam int ADDR_W = $clog2(BYTES);

  localparam logic [1:0] WR_SIZE_BYTE = 2'd0;  // lane 0 only
  localparam logic [1:0] WR_SIZE_WORD = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_CAP,
    STORE,
    RMW_RD,
    RMW_WR,
    FAULT,
    RESP
  } mem_state_t;

endpackage : xm_mem_pkg

// File: rtl/mem_lane_fmt.sv
// -----------------------------------------------------------------------------
// mem_lane_fmt
// Combinational byte-lane formatting between the 16-bit memory word and
// byte-sized CPU accesses. Little-endian: lane 0 = bits [7:0].
//   rd_data_i  : word read from memory
//   lane_i     : byte lane to extract (byte address bit 0)
//   wbyte_i    : store byte to merge into lane 1 for read-modify-write
//   byte_ext_o : selected lane, zero-extended to a word
//   rmw_word_o : {wbyte_i, rd_data_i lane 0}, written back as a full word
// -----------------------------------------------------------------------------
module mem_lane_fmt
  import xm_mem_pkg::*;
(
  input  logic [WORD-1:0] rd_data_i,
  input  logic            lane_i,
  input  logic [BYTE-1:0] wbyte_i,
  output logic [WORD-1:0] byte_ext_o,
  output logic [WORD-1:0] rmw_word_o
);

  logic [BYTE-1:0] lane_byte;

  assign lane_byte  = lane_i ? rd_data_i[WORD-1:BYTE] : rd_data_i[BYTE-1:0];
  assign byte_ext_o = {{(WORD-BYTE){1'b0}}, lane_byte};

  // Memory byte enables only reach lane 0, so an odd-byte store rewrites the
  // whole word, keeping the existing lane 0 byte.
  assign rmw_word_o = {wbyte_i, rd_data_i[BYTE-1:0]};

endmodule : mem_lane_fmt

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Data-side load/store sequencer in front of the X-Makina byte-addressable
// memory. Takes one byte-addressed CPU request at a time, converts it to the
// memory's word index, single-cycle write strobes and registered-read timing,
// and returns a one-cycle response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_wr, req_byte           1 = store / 1 = byte access
//   req_addr, req_wdata        byte address, store data (byte store: [7:0])
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata                  load result, held until the next load completes
//   rsp_fault                  misaligned word access, no memory op performed
//   mem_rd, mem_rd_addr        read strobe + word index; data next cycle
//   mem_rd_data                memory read data
//   mem_wr, mem_wr_size        write strobe + size (0 = lane 0 byte, 1 = word)
//   mem_wr_addr, mem_wr_data   write word index and data
//
// Configuration
//   MEM_ACCESS_ALIGN_CHECK_EN  defined: odd-address word access faults.
//                              undefined: odd word addresses are aligned down
//                              and rsp_fault is tied low.
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import xm_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [WORD-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD-1:0]   mem_rd_data,
  output logic              mem_wr,
  output logic [1:0]        mem_wr_size,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WORD-1:0]   mem_wr_data
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD-1:0]   wdata_q;
  logic              wr_q;
  logic              byte_q;
  logic [WORD-1:0]   rdata_q;
  logic              accept;
  logic [WORD-1:0]   byte_ext;
  logic [WORD-1:0]   rmw_word;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // Both memory ports address the latched request; bit 0 only selects a lane.
  assign mem_rd_addr = {1'b0, addr_q[ADDR_W-1:1]};
  assign mem_wr_addr = {1'b0, addr_q[ADDR_W-1:1]};
  assign rsp_rdata   = rdata_q;

  mem_lane_fmt u_lane_fmt (
    .rd_data_i  (mem_rd_data),
    .lane_i     (addr_q[0]),
    .wbyte_i    (wdata_q[BYTE-1:0]),
    .byte_ext_o (byte_ext),
    .rmw_word_o (rmw_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_wr;
        byte_q  <= req_byte;
      end
      // mem_rd_data is valid here, one cycle after the LOAD read strobe.
      if (state_q == LOAD_CAP && !wr_q) begin
        rdata_q <= byte_q ? byte_ext : mem_rd_data;
      end
    end
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= !req_byte && req_addr[0];
    end
  end

  assign rsp_fault = (state_q == RESP) && fault_q;
`else
  assign rsp_fault = 1'b0;
`endif

  // Moore outputs: strobes depend on state_q only, so an asynchronous reset
  // drops them immediately and an aborted RMW never reaches its write.
  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    rsp_valid   = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wr_size = WR_SIZE_BYTE;
    mem_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
          if (!req_byte && req_addr[0]) state_d = FAULT;
          else
`endif
          if (!req_wr)                     state_d = LOAD;
          else if (req_byte && req_addr[0]) state_d = RMW_RD;
          else                              state_d = STORE;
        end
      end
      LOAD: begin
        mem_rd  = 1'b1;
        state_d = LOAD_CAP;
      end
      LOAD_CAP: state_d = RESP;
      STORE: begin
        mem_wr      = 1'b1;
        mem_wr_size = byte_q ? WR_SIZE_BYTE : WR_SIZE_WORD;
        mem_wr_data = wdata_q;
        state_d     = RESP;
      end
      RMW_RD: begin
        mem_rd  = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_wr      = 1'b1;
        mem_wr_size = WR_SIZE_WORD;
        mem_wr_data = rmw_word;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      // FAULT issues no strobes; without the alignment check it is unreachable.
      default: state_d = (state_q == FAULT) ? RESP : IDLE;
    endcase
  end

endmodule : mem_access_ctrl
